// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Purpose:
//   Two-entry elastic buffer between the fetch stage and the decode stage.
//   Each accepted {pc, inst} pair is stored with two early exception flags:
//     - misalign : pc[1:0] != 2'b00
//     - illegal  : inst[1:0] != 2'b11 (not a 32-bit encoding)
//   The buffer absorbs one cycle of decode back-pressure. A synchronous flush
//   discards every held entry when fetch redirects on a taken branch.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   in_valid      fetch presents a valid {pc_in, inst_in}
//   in_ready      buffer can accept this cycle (state-derived only)
//   pc_in         address of the fetched word
//   inst_in       fetched instruction
//   flush         redirect; discard all held entries
//   out_valid     head entry valid for decode
//   out_ready     decode consumes the head this cycle
//   pc_out        head entry PC
//   inst_out      head entry instruction
//   misalign_out  head entry misaligned-PC flag
//   illegal_out   head entry non-32-bit-encoding flag
//   count         current occupancy, 0..2
//
// Configuration macro:
//   IF_ID_BUBBLE_NOP_EN  when defined, an empty buffer presents
//                        inst_out = 32'h0000_0013 (addi x0,x0,0) with both
//                        flags forced low. When undefined, inst_out shows the
//                        raw entry at the read pointer and must be qualified
//                        with out_valid.
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              misalign_out,
  output logic              illegal_out,
  output logic [1:0]        count
);

  logic [PC_W-1:0]   r_pc   [2];
  logic [INST_W-1:0] r_inst [2];
  logic [1:0]        r_misalign;
  logic [1:0]        r_illegal;
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_misalign_in;
  logic              w_illegal_in;

  // Handshake flags come from occupancy alone, so there is no combinational
  // path from out_ready to in_ready. A pop while full frees a slot that
  // only becomes visible on in_ready in the following cycle.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);

  // Flush wins over any same-cycle push or pop.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Exception flags are evaluated once, at push time, and travel with the entry.
  assign w_misalign_in = (pc_in[1:0] != 2'b00);
  assign w_illegal_in  = (inst_in[1:0] != 2'b11);

  // Entry storage. Only the slot under the write pointer is ever written, so
  // a resident entry is never modified. Flush leaves contents in place; they
  // become unreachable because the occupancy drops to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
      r_misalign <= '0;
      r_illegal  <= '0;
    end else if (w_push) begin
      r_pc[r_wp]       <= pc_in;
      r_inst[r_wp]     <= inst_in;
      r_misalign[r_wp] <= w_misalign_in;
      r_illegal[r_wp]  <= w_illegal_in;
    end
  end

  // Pointers and occupancy. One-bit pointers wrap naturally modulo 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_wp <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count  = r_count;
  assign pc_out = r_pc[r_rp];

`ifdef IF_ID_BUBBLE_NOP_EN
  // Present a canonical NOP whenever the buffer is empty so decode sees a
  // harmless bubble even without qualifying on out_valid.
  assign inst_out     = out_valid ? r_inst[r_rp] : INST_W'(32'h0000_0013);
  assign misalign_out = out_valid && r_misalign[r_rp];
  assign illegal_out  = out_valid && r_illegal[r_rp];
`else
  assign inst_out     = r_inst[r_rp];
  assign misalign_out = r_misalign[r_rp];
  assign illegal_out  = r_illegal[r_rp];
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Self-checking bench for if_id_buffer. A queue holds the entries the buffer
// is expected to contain; entries are pushed when the bench drives an
// accepted word and popped when decode consumes the head. Each scenario task
// compares the DUT outputs against the queue head and occupancy.
// Honours IF_ID_BUBBLE_NOP_EN for the expected empty-buffer instruction.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
    logic        ill;
  } entry_t;

`ifdef IF_ID_BUBBLE_NOP_EN
  localparam logic [31:0] EMPTY_INST = 32'h0000_0013;
`else
  localparam logic [31:0] EMPTY_INST = 32'h0000_0000;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pc_in;
  logic [31:0] inst_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc_out;
  logic [31:0] inst_out;
  logic        misalign_out;
  logic        illegal_out;
  logic [1:0]  count;

  entry_t sbq[$];
  int     checkCount = 0;
  int     passCount  = 0;

  if_id_buffer #(.PC_W(64), .INST_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .misalign_out (misalign_out),
    .illegal_out  (illegal_out),
    .count        (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Set the fetch/decode inputs for the next edge.
  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    pc_in     = pc;
    inst_in   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one edge and update the expected contents from the driven inputs.
  task automatic tick();
    entry_t e;
    int     sz;
    @(posedge clk);
    sz = sbq.size();
    if (flush) begin
      sbq.delete();
    end else begin
      if (sz != 0 && out_ready) void'(sbq.pop_front());
      if (in_valid && sz < 2) begin
        e.pc   = pc_in;
        e.inst = inst_in;
        e.mis  = (pc_in % 4) != 0;
        e.ill  = (inst_in & 32'h3) != 32'h3;
        sbq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #3;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); else passCount++;
    checkCount++; if (count !== 2'd0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passCount++;
    checkCount++; if (pc_out !== 64'h0) $display("[TB] FAIL reset_pc_out: got %h want 0", pc_out); else passCount++;
    checkCount++; if (inst_out !== EMPTY_INST) $display("[TB] FAIL reset_inst_out: got %h want %h", inst_out, EMPTY_INST); else passCount++;
    checkCount++; if ({misalign_out, illegal_out} !== 2'b00) $display("[TB] FAIL reset_flags: got %b want 00", {misalign_out, illegal_out}); else passCount++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkCount++; if (out_valid !== 1'b0 || count !== 2'd0) $display("[TB] FAIL post_reset_idle: got valid=%0b count=%0d want 0/0", out_valid, count); else passCount++;
  endtask

  task automatic test_single();
    drive(1'b1, 64'h0, 32'h0050_0093, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL single_valid: got %0b want 1", out_valid); else passCount++;
    checkCount++; if (count !== 2'(sbq.size())) $display("[TB] FAIL single_count: got %0d want %0d", count, sbq.size()); else passCount++;
    if (sbq.size() != 0) begin
      checkCount++; if (pc_out !== sbq[0].pc) $display("[TB] FAIL single_pc: got %h want %h", pc_out, sbq[0].pc); else passCount++;
      checkCount++; if (inst_out !== sbq[0].inst) $display("[TB] FAIL single_inst: got %h want %h", inst_out, sbq[0].inst); else passCount++;
    end
    tick();
    checkCount++; if (out_valid !== 1'b0 || count !== 2'd0) $display("[TB] FAIL single_popped: got valid=%0b count=%0d want 0/0", out_valid, count); else passCount++;
  endtask

  task automatic test_backpressure();
    logic [63:0] pcs [3];
    pcs[0] = 64'h0; pcs[1] = 64'h4; pcs[2] = 64'h8;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], 32'h0000_0013 | (32'(i) << 20), 1'b0, 1'b0);
      tick();
    end
    checkCount++; if (count !== 2'd2) $display("[TB] FAIL bp_full_count: got %0d want 2", count); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_ready: got %0b want 0", in_ready); else passCount++;
    // Pop while still presenting 0x8: refused because in_ready is still low.
    drive(1'b1, 64'h8, 32'h0020_0013, 1'b1, 1'b0);
    checkCount++; if (pc_out !== sbq[0].pc) $display("[TB] FAIL bp_head0: got %h want %h", pc_out, sbq[0].pc); else passCount++;
    tick();
    checkCount++; if (count !== 2'(sbq.size()) || in_ready !== 1'b1) $display("[TB] FAIL bp_after_pop: got count=%0d ready=%0b want %0d/1", count, in_ready, sbq.size()); else passCount++;
    checkCount++; if (pc_out !== sbq[0].pc) $display("[TB] FAIL bp_head1: got %h want %h", pc_out, sbq[0].pc); else passCount++;
    tick();
    checkCount++; if (pc_out !== 64'h8 || pc_out !== sbq[0].pc) $display("[TB] FAIL bp_represent: got %h want %h", pc_out, sbq[0].pc); else passCount++;
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %0b want 0", out_valid); else passCount++;
  endtask

  task automatic test_flush();
    drive(1'b1, 64'h10, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h14, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h18, 32'h0000_0013, 1'b1, 1'b1); tick();
    checkCount++; if (count !== 2'd0 || out_valid !== 1'b0) $display("[TB] FAIL flush_empty: got count=%0d valid=%0b want 0/0", count, out_valid); else passCount++;
`ifdef IF_ID_BUBBLE_NOP_EN
    checkCount++; if (inst_out !== EMPTY_INST) $display("[TB] FAIL flush_nop: got %h want %h", inst_out, EMPTY_INST); else passCount++;
`endif
    drive(1'b1, 64'h40, 32'h0010_0093, 1'b0, 1'b0); tick();
    checkCount++; if (count !== 2'(sbq.size()) || pc_out !== sbq[0].pc) $display("[TB] FAIL flush_first: got pc=%h count=%0d want %h/%0d", pc_out, count, sbq[0].pc, sbq.size()); else passCount++;
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_flags();
    logic [63:0] pcs   [3];
    logic [31:0] insts [3];
    pcs[0] = 64'h6; insts[0] = 32'h0000_0001;
    pcs[1] = 64'h4; insts[1] = 32'h0000_0013;
    pcs[2] = 64'h2; insts[2] = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], insts[i], 1'b0, 1'b0); tick();
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      checkCount++;
      if (misalign_out !== sbq[0].mis || illegal_out !== sbq[0].ill)
        $display("[TB] FAIL flags_%0d: got mis=%0b ill=%0b want %0b/%0b", i, misalign_out, illegal_out, sbq[0].mis, sbq[0].ill);
      else passCount++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'h100 + 64'(4 * i), ($urandom() & 32'hFFFF_FFFC) | 32'h3, 1'b1, 1'b0);
      tick();
      checkCount++;
      if (count !== 2'(sbq.size()) || pc_out !== sbq[0].pc || inst_out !== sbq[0].inst)
        $display("[TB] FAIL b2b_%0d: got pc=%h inst=%h count=%0d want %h/%h/%0d", i, pc_out, inst_out, count, sbq[0].pc, sbq[0].inst, sbq.size());
      else passCount++;
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); tick();
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %0b want 0", out_valid); else passCount++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h200, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b1, 64'h204, 32'h0000_0013, 1'b0, 1'b0); tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    sbq.delete();
    #1;
    checkCount++; if (out_valid !== 1'b0 || count !== 2'd0 || pc_out !== 64'h0) $display("[TB] FAIL async_reset: got valid=%0b count=%0d pc=%h want 0/0/0", out_valid, count, pc_out); else passCount++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL async_reset_release: got ready=%0b valid=%0b want 1/0", in_ready, out_valid); else passCount++;
  endtask

  initial begin
    drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_flags();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic buffer between the fetch stage (program counter plus instruction memory plus next-PC select) and the decode stage.
- Captures each fetched `{pc, inst}` pair with a valid/ready handshake.
- Absorbs one cycle of decode back-pressure without losing a fetched word.
- Supports a synchronous flush when the fetch stage redirects on a taken branch.
- Tags every entry with two early exception flags: misaligned PC and non-32-bit encoding.

## Interface
Parameters:
- `PC_W`, 64, program-counter width
- `INST_W`, 32, instruction width

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, port `rst`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a valid `{pc_in, inst_in}`
- `in_ready`  out  1  buffer can accept this cycle
- `pc_in`  in  PC_W  address of the fetched word
- `inst_in`  in  INST_W  fetched instruction
- `flush`  in  1  redirect; discard all held entries
- `out_valid`  out  1  head entry valid for decode
- `out_ready`  in  1  decode consumes the head this cycle
- `pc_out`  out  PC_W  head entry PC
- `inst_out`  out  INST_W  head entry instruction
- `misalign_out`  out  1  head entry has `pc[1:0] != 2'b00`
- `illegal_out`  out  1  head entry has `inst[1:0] != 2'b11`
- `count`  out  2  current occupancy, 0..2

## Operation
Storage and pointers:
- Storage is 2 entries of `{pc, inst, misalign, illegal}`.
- 1-bit write pointer `wp`, 1-bit read pointer `rp`, 2-bit `count`.
- Flags are computed from `pc_in`/`inst_in` at push time and stored with the entry.

Handshake:
- `in_ready = (count != 2)`, derived from state only; there is no combinational path from `out_ready`.
- Push: `in_valid && in_ready` writes `entry[wp]` and toggles `wp`.
- Pop: `out_valid && out_ready` toggles `rp`.
- `out_valid = (count != 0)`.
- `pc_out`, `inst_out` and both flags are driven from `entry[rp]`.

Occupancy update, in priority order:
- Flush: `count <= 0`, `wp <= 0`, `rp <= 0`. A push or pop in the same cycle is ignored, and no entry survives.
- Push and pop together: `count` unchanged, both pointers advance.
- Push only: `count + 1`.
- Pop only: `count - 1`.

Boundary conditions:
- Full (count 2): `in_valid` is ignored. A same-cycle pop frees a slot visible next cycle, so `in_ready` rises one cycle after the pop.
- Empty (count 0): `out_ready` is ignored and no pop occurs.
- Pointers wrap modulo 2.
- Held entry contents are never modified while resident; only the write slot changes.

Reset:
- Reset asserted (mid-operation included) clears `count`, `wp`, `rp` and all storage to 0 immediately.
- After reset: `out_valid = 0`, `in_ready = 1`, `count = 0`, `misalign_out = 0`, `illegal_out = 0`, `pc_out = 0`.
- `inst_out` after reset: see Configuration.

## Timing
- Latency: a word pushed at edge N is visible on the outputs after edge N, i.e. `out_valid` is high in cycle N+1. There is no input-to-output combinational path.
- Throughput: one word per cycle when `out_ready` is held high.
- Flush sampled at edge N: `out_valid = 0` from cycle N+1.
- A push in cycle N+1 is accepted normally; that is the new fetch target.
- Reset deassertion: outputs are stable at the reset values until the first push.

## Configuration
- `IF_ID_BUBBLE_NOP_EN`, defined:
  - `inst_out` is forced to `32'h0000_0013` (`addi x0,x0,0`) whenever `out_valid == 0`, including during reset and after flush.
  - `misalign_out` and `illegal_out` are forced to 0 under the same conditions.
- Not defined: `inst_out` shows `entry[rp]` raw, which is 0 after reset and stale data after pops or flush. Decode must qualify it with `out_valid`.

## Test plan
- Reset, then push pc `0x0`, inst `0x00500093` with `out_ready = 1`:
  - `out_valid = 1` next cycle, `pc_out = 0x0`, `inst_out = 0x00500093`, `count = 1`.
  - Popped the following cycle.
- Push 3 words (pc `0x0`, `0x4`, `0x8`) with `out_ready = 0`:
  - `count` reaches 2 and `in_ready = 0`.
  - Third word is refused.
  - Raising `out_ready` yields `0x0`, `0x4`; `0x8` is accepted when re-presented.
- Count 2, assert `flush` together with `in_valid` and `out_ready`:
  - Next cycle `count = 0`, `out_valid = 0`.
  - The next push at pc `0x40` is the first output.
- Push pc `0x6`, inst `0x00000001` -> `misalign_out = 1`, `illegal_out = 1` at the head.
- Drop `rst` low while `count = 2` -> `out_valid`, `count` and `pc_out` go to 0 immediately, without waiting for a clock edge.
- With `IF_ID_BUBBLE_NOP_EN` defined -> `inst_out = 0x00000013` when empty. Without it -> `inst_out = 0` after reset.
